// File: rtl/timer_cfg_sequencer.sv
// Configuration sequencer for the 32-bit match timer.
// The host writes shadow copies of TCR, PR, MR0-MR3 and MCR. A commit runs
// a fixed sequence: hold the counters in reset, load all match/prescale
// values on one edge, release the counter reset, then restore the enable.
// Every output is a register, so the timer never sees a partial update.
module timer_cfg_sequencer #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        commit,
    input  logic        stop,
    output logic        wr_err,
    output logic        busy,
    output logic        done,
    output logic [7:0]  tcr_val,
    output logic [31:0] pr_val,
    output logic [31:0] mr0_val,
    output logic [31:0] mr1_val,
    output logic [31:0] mr2_val,
    output logic [31:0] mr3_val,
    output logic [15:0] mcr_val
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        LOAD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] HOLD_N    = 4'(HOLD_CYCLES);
    localparam logic [7:0] TCR_RST   = 8'h02;  // counter reset asserted, disabled
    localparam logic [7:0] TCR_CLR   = 8'h00;  // counter reset released, still disabled
    localparam logic [7:0] TCR_NORST = 8'hFD;  // strips the counter-reset bit
    localparam logic [2:0] ADDR_RSVD = 3'd7;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_wr_err;
    logic [7:0]  r_tcr;
    logic [31:0] r_pr;
    logic [31:0] r_mr0;
    logic [31:0] r_mr1;
    logic [31:0] r_mr2;
    logic [31:0] r_mr3;
    logic [15:0] r_mcr;
    logic [7:0]  r_tcr_snap;

    logic [7:0]  r_tcr_sh;
    logic [31:0] r_pr_sh;
    logic [31:0] r_mr0_sh;
    logic [31:0] r_mr1_sh;
    logic [31:0] r_mr2_sh;
    logic [31:0] r_mr3_sh;
    logic [15:0] r_mcr_sh;

    logic w_idle;
    logic w_wr_ok;
    logic w_wr_bad;

    assign w_idle   = (r_state == IDLE);
    assign w_wr_ok  = wr_en && w_idle && (wr_addr != ADDR_RSVD);
    assign w_wr_bad = wr_en && (!w_idle || (wr_addr == ADDR_RSVD));

    // Shadow registers: only accepted while idle, upper bits dropped for TCR/MCR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcr_sh <= '0;
            r_pr_sh  <= '0;
            r_mr0_sh <= '0;
            r_mr1_sh <= '0;
            r_mr2_sh <= '0;
            r_mr3_sh <= '0;
            r_mcr_sh <= '0;
        end else if (w_wr_ok) begin
            case (wr_addr)
                3'd0:    r_tcr_sh <= wr_data[7:0];
                3'd1:    r_pr_sh  <= wr_data;
                3'd2:    r_mr0_sh <= wr_data;
                3'd3:    r_mr1_sh <= wr_data;
                3'd4:    r_mr2_sh <= wr_data;
                3'd5:    r_mr3_sh <= wr_data;
                3'd6:    r_mcr_sh <= wr_data[15:0];
                default: ;
            endcase
        end
    end

    // Rejected-write flag: one pulse per rejected write, back-to-back allowed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_wr_bad;
        end
    end

    // Reprogramming FSM with registered timer-facing outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tcr      <= TCR_RST;
            r_pr       <= '0;
            r_mr0      <= '0;
            r_mr1      <= '0;
            r_mr2      <= '0;
            r_mr3      <= '0;
            r_mcr      <= '0;
            r_tcr_snap <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // commit has priority over stop
                    if (commit) begin
                        r_state <= HOLD;
                        r_cnt   <= 4'd1;
                        r_busy  <= 1'b1;
                        r_tcr   <= TCR_RST;
                    end else if (stop) begin
                        r_tcr[0] <= 1'b0;
                    end
                end
                HOLD: begin
                    if (r_cnt == HOLD_N) begin
                        // all values change on this single edge
                        r_state    <= LOAD;
                        r_pr       <= r_pr_sh;
                        r_mr0      <= r_mr0_sh;
                        r_mr1      <= r_mr1_sh;
                        r_mr2      <= r_mr2_sh;
                        r_mr3      <= r_mr3_sh;
                        r_mcr      <= r_mcr_sh;
                        r_tcr_snap <= r_tcr_sh;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                LOAD: begin
                    r_state <= RELEASE;
                    r_tcr   <= TCR_CLR;
                end
                RELEASE: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_tcr   <= r_tcr_snap & TCR_NORST;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign wr_err  = r_wr_err;
    assign busy    = r_busy;
    assign done    = r_done;
    assign tcr_val = r_tcr;
    assign pr_val  = r_pr;
    assign mr0_val = r_mr0;
    assign mr1_val = r_mr1;
    assign mr2_val = r_mr2;
    assign mr3_val = r_mr3;
    assign mcr_val = r_mcr;

endmodule

// File: tb/tb_timer_cfg_sequencer.sv
// Bench for timer_cfg_sequencer: cycle-by-cycle vector table plus a
// hand-written asynchronous-reset-during-load sequence.
module tb_timer_cfg_sequencer;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        commit;
    logic        stop;
    logic        wr_err;
    logic        busy;
    logic        done;
    logic [7:0]  tcr_val;
    logic [31:0] pr_val;
    logic [31:0] mr0_val;
    logic [31:0] mr1_val;
    logic [31:0] mr2_val;
    logic [31:0] mr3_val;
    logic [15:0] mcr_val;

    timer_cfg_sequencer #(.HOLD_CYCLES(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .commit  (commit),
        .stop    (stop),
        .wr_err  (wr_err),
        .busy    (busy),
        .done    (done),
        .tcr_val (tcr_val),
        .pr_val  (pr_val),
        .mr0_val (mr0_val),
        .mr1_val (mr1_val),
        .mr2_val (mr2_val),
        .mr3_val (mr3_val),
        .mcr_val (mcr_val)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  addr;
        logic [31:0] data;
        logic        cm;
        logic        st;
        logic        x_err;
        logic        x_busy;
        logic        x_done;
        logic [7:0]  x_tcr;
        logic [31:0] x_pr;
        logic [31:0] x_mr0;
        logic [31:0] x_mr1;
        logic [31:0] x_mr2;
        logic [31:0] x_mr3;
        logic [15:0] x_mcr;
    } vec_t;

    vec_t vecs[$];

    // expected timer-value outputs, updated as the table is built
    logic [31:0] e_pr, e_mr0, e_mr1, e_mr2, e_mr3;
    logic [15:0] e_mcr;

    int n_vec;
    int n_bad;

    function automatic vec_t mk(input string n, input logic we, input logic [2:0] a,
                                input logic [31:0] d, input logic cm, input logic st,
                                input logic er, input logic bz, input logic dn,
                                input logic [7:0] t);
        vec_t v;
        v.name = n; v.we = we; v.addr = a; v.data = d; v.cm = cm; v.st = st;
        v.x_err = er; v.x_busy = bz; v.x_done = dn; v.x_tcr = t;
        v.x_pr = e_pr; v.x_mr0 = e_mr0; v.x_mr1 = e_mr1;
        v.x_mr2 = e_mr2; v.x_mr3 = e_mr3; v.x_mcr = e_mcr;
        return v;
    endfunction

    task automatic add(input string n, input logic we, input logic [2:0] a,
                       input logic [31:0] d, input logic cm, input logic st,
                       input logic er, input logic bz, input logic dn,
                       input logic [7:0] t);
        vecs.push_back(mk(n, we, a, d, cm, st, er, bz, dn, t));
    endtask

    task automatic check_out(input vec_t v);
        n_vec++;
        if (wr_err !== v.x_err || busy !== v.x_busy || done !== v.x_done ||
            tcr_val !== v.x_tcr || pr_val !== v.x_pr || mr0_val !== v.x_mr0 ||
            mr1_val !== v.x_mr1 || mr2_val !== v.x_mr2 || mr3_val !== v.x_mr3 ||
            mcr_val !== v.x_mcr) begin
            n_bad++;
            $display("FAIL %s: got err=%b busy=%b done=%b tcr=%h pr=%h mr=%h/%h/%h/%h mcr=%h, want err=%b busy=%b done=%b tcr=%h pr=%h mr=%h/%h/%h/%h mcr=%h",
                     v.name, wr_err, busy, done, tcr_val, pr_val, mr0_val, mr1_val,
                     mr2_val, mr3_val, mcr_val, v.x_err, v.x_busy, v.x_done, v.x_tcr,
                     v.x_pr, v.x_mr0, v.x_mr1, v.x_mr2, v.x_mr3, v.x_mcr);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] a, input logic [31:0] d,
                         input logic cm, input logic st);
        wr_en = we; wr_addr = a; wr_data = d; commit = cm; stop = st;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        e_pr = '0; e_mr0 = '0; e_mr1 = '0; e_mr2 = '0; e_mr3 = '0; e_mcr = '0;
        reset = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);

        // ---- build the vector table (HOLD_CYCLES = 2) ----
        add("idle_after_rst", 0, 3'd0, 32'h0,         0, 0, 0, 0, 0, 8'h02);
        add("wr_pr",          1, 3'd1, 32'd3,         0, 0, 0, 0, 0, 8'h02);
        add("wr_mr0",         1, 3'd2, 32'd10,        0, 0, 0, 0, 0, 8'h02);
        add("wr_mr2",         1, 3'd4, 32'h1234_5678, 0, 0, 0, 0, 0, 8'h02);
        add("wr_mr3",         1, 3'd5, 32'h8000_0001, 0, 0, 0, 0, 0, 8'h02);
        add("wr_mcr",         1, 3'd6, 32'hFFFF_0003, 0, 0, 0, 0, 0, 8'h02);
        add("wr_tcr",         1, 3'd0, 32'hFFFF_FF01, 0, 0, 0, 0, 0, 8'h02);
        add("stop_pre_run",   0, 3'd0, 32'h0,         0, 1, 0, 0, 0, 8'h02);
        add("wr_rsvd",        1, 3'd7, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 8'h02);
        add("wr_rsvd_b2b",    1, 3'd7, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 8'h02);
        add("err_clear",      0, 3'd0, 32'h0,         0, 0, 0, 0, 0, 8'h02);
        add("commit",         0, 3'd0, 32'h0,         1, 0, 0, 1, 0, 8'h02);
        add("hold_stop_ign",  0, 3'd0, 32'h0,         0, 1, 0, 1, 0, 8'h02);
        e_pr = 32'd3; e_mr0 = 32'd10; e_mr2 = 32'h1234_5678;
        e_mr3 = 32'h8000_0001; e_mcr = 16'h0003;
        add("load_wr_busy",   1, 3'd3, 32'd5,         0, 0, 1, 1, 0, 8'h02);
        add("release",        0, 3'd0, 32'h0,         0, 0, 0, 1, 0, 8'h00);
        add("done",           0, 3'd0, 32'h0,         0, 0, 0, 0, 1, 8'h01);
        add("idle_post",      0, 3'd0, 32'h0,         0, 0, 0, 0, 0, 8'h01);
        add("stop_run",       0, 3'd0, 32'h0,         0, 1, 0, 0, 0, 8'h00);
        add("idle_stopped",   0, 3'd0, 32'h0,         0, 0, 0, 0, 0, 8'h00);
        add("wr_tcr03",       1, 3'd0, 32'h0000_0003, 0, 0, 0, 0, 0, 8'h00);
        add("wr_commit",      1, 3'd2, 32'hDEAD_BEEF, 1, 0, 0, 1, 0, 8'h02);
        add("commit_busy",    0, 3'd0, 32'h0,         1, 0, 0, 1, 0, 8'h02);
        e_mr0 = 32'hDEAD_BEEF;
        add("load2",          0, 3'd0, 32'h0,         0, 0, 0, 1, 0, 8'h02);
        add("commit_busy2",   0, 3'd0, 32'h0,         1, 0, 0, 1, 0, 8'h00);
        add("done2_bit1clr",  0, 3'd0, 32'h0,         0, 0, 0, 0, 1, 8'h01);
        add("no_requeue",     0, 3'd0, 32'h0,         0, 0, 0, 0, 0, 8'h01);
        add("stop_commit",    0, 3'd0, 32'h0,         1, 1, 0, 1, 0, 8'h02);
        add("held_h1",        0, 3'd0, 32'h0,         1, 0, 0, 1, 0, 8'h02);
        add("held_load",      0, 3'd0, 32'h0,         1, 0, 0, 1, 0, 8'h02);
        add("held_rel",       0, 3'd0, 32'h0,         1, 0, 0, 1, 0, 8'h00);
        add("held_done",      0, 3'd0, 32'h0,         1, 0, 0, 0, 1, 8'h01);
        add("held_restart",   0, 3'd0, 32'h0,         1, 0, 0, 1, 0, 8'h02);
        add("held2_h1",       0, 3'd0, 32'h0,         0, 0, 0, 1, 0, 8'h02);
        add("held2_load",     0, 3'd0, 32'h0,         0, 0, 0, 1, 0, 8'h02);
        add("held2_rel",      0, 3'd0, 32'h0,         0, 0, 0, 1, 0, 8'h00);
        add("held2_done",     0, 3'd0, 32'h0,         0, 0, 0, 0, 1, 8'h01);
        add("idle_end",       0, 3'd0, 32'h0,         0, 0, 0, 0, 0, 8'h01);

        // ---- reset ----
        #2 reset = 1'b1;
        #1;
        e_pr = '0; e_mr0 = '0; e_mr1 = '0; e_mr2 = '0; e_mr3 = '0; e_mcr = '0;
        check_out(mk("reset_state", 0, 3'd0, 32'h0, 0, 0, 0, 0, 0, 8'h02));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // ---- table ----
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].cm, vecs[i].st);
            @(posedge clk);
            #1;
            check_out(vecs[i]);
        end

        // ---- asynchronous reset while in LOAD ----
        e_pr = 32'd3; e_mr0 = 32'hDEAD_BEEF; e_mr1 = '0; e_mr2 = 32'h1234_5678;
        e_mr3 = 32'h8000_0001; e_mcr = 16'h0003;
        @(negedge clk);
        drive(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_out(mk("rst_seq_commit", 0, 3'd0, 32'h0, 1, 0, 0, 1, 0, 8'h02));
        @(negedge clk);
        drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_out(mk("rst_seq_in_load", 0, 3'd0, 32'h0, 0, 0, 0, 1, 0, 8'h02));
        #2 reset = 1'b1;
        #1;
        e_pr = '0; e_mr0 = '0; e_mr1 = '0; e_mr2 = '0; e_mr3 = '0; e_mcr = '0;
        check_out(mk("rst_mid_load", 0, 3'd0, 32'h0, 0, 0, 0, 0, 0, 8'h02));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_out(mk("post_rst_1", 0, 3'd0, 32'h0, 0, 0, 0, 0, 0, 8'h02));
        @(posedge clk);
        #1;
        check_out(mk("post_rst_2", 0, 3'd0, 32'h0, 0, 0, 0, 0, 0, 8'h02));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
